// File: rtl/comparator_seq_ctrl.sv
// comparator_seq_ctrl
// Sequential magnitude comparator: steps a single 2-bit compare slice from
// the MSB pair of the captured operands down to the LSB pair, one slice per
// clock, behind a start/busy/done handshake. The result is presented as
// registered one-hot L/E/G flags that hold until the next completed compare.
//
// Build option:
//   COMPARATOR_SEQ_EARLY_EXIT_EN - when defined, RUN ends on the first slice
//   that differs, or after slice 0 when every slice is equal. When undefined,
//   RUN always visits all WIDTH/2 slices for fixed latency. The L/E/G result is
//   identical in both builds; only the done timing changes.
module comparator_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             L,
  output logic             E,
  output logic             G
);

  localparam int S     = WIDTH / 2;
  localparam int IDX_W = (S > 1) ? $clog2(S) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IDX_W-1:0] idx;
  logic             decided;
  logic             res_g;

  logic [1:0]       a_sl;
  logic [1:0]       b_sl;
  logic             diff;
  logic             fin_dec;
  logic             fin_g;
  logic             last;

  // Select the operand slice pair addressed by the current slice index.
  always_comb begin
    a_sl = 2'b00;
    b_sl = 2'b00;
    for (int i = 0; i < S; i++) begin
      if (idx == IDX_W'(i)) begin
        a_sl = a_q[2*i +: 2];
        b_sl = b_q[2*i +: 2];
      end
    end
  end

  // Fold the current slice into the sticky decision; an earlier (more
  // significant) differing slice always wins over later ones.
  always_comb begin
    diff    = (a_sl != b_sl);
    fin_dec = decided | diff;
    fin_g   = decided ? res_g : (a_sl > b_sl);
`ifdef COMPARATOR_SEQ_EARLY_EXIT_EN
    last    = (idx == '0) | diff;
`else
    last    = (idx == '0);
`endif
  end

  // Control FSM, operand capture, slice walk and result flag update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx     <= '0;
      decided <= 1'b0;
      res_g   <= 1'b0;
      L       <= 1'b0;
      E       <= 1'b0;
      G       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            idx     <= IDX_W'(S - 1);
            decided <= 1'b0;
            res_g   <= 1'b0;
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (last) begin
            L     <= fin_dec & ~fin_g;
            E     <= ~fin_dec;
            G     <= fin_dec & fin_g;
            state <= ST_DONE;
          end else begin
            idx     <= idx - 1'b1;
            decided <= fin_dec;
            res_g   <= fin_g;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Handshake outputs decode directly from the registered state.
  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_comparator_seq_ctrl.sv
// Testbench for comparator_seq_ctrl: directed scenarios plus randomized
// compares on a WIDTH=8 instance, and a WIDTH=2 instance for the single-slice
// case. Expected results and latencies come from a plain arithmetic model.
module tb_comparator_seq_ctrl;

`ifdef COMPARATOR_SEQ_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy, done, L, E, G;

  logic       start2;
  logic [1:0] a2;
  logic [1:0] b2;
  logic       busy2, done2, L2, E2, G2;

  int         n_chk;
  int         n_fail;
  logic [2:0] prev;

  comparator_seq_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .L(L), .E(E), .G(G)
  );

  comparator_seq_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .L(L2), .E(E2), .G(G2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // {L,E,G} from plain unsigned comparison.
  function automatic logic [2:0] exp_leg(input int unsigned x, input int unsigned y);
    if (x < y)       return 3'b100;
    else if (x == y) return 3'b010;
    else             return 3'b001;
  endfunction

  // RUN cycles for an 8-bit compare: all 4 slices, or up to the first
  // differing slice when early exit is built in.
  function automatic int exp_k8(input int unsigned x, input int unsigned y);
    int k;
    k = 0;
    if (!EARLY) return 4;
    for (int i = 3; i >= 0; i--) begin
      k++;
      if (((x >> (2*i)) & 3) != ((y >> (2*i)) & 3)) return k;
    end
    return 4;
  endfunction

  task automatic start8(input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    start = 1'b1;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    chk("busy_t0", busy, 1);
    chk("done_t0", done, 0);
  endtask

  // n0 = number of edges after t0 already consumed by the caller.
  task automatic wait8(input logic [7:0] x, input logic [7:0] y, input int n0);
    int n;
    logic [2:0] e;
    n = n0;
    e = exp_leg(x, y);
    while (!done && n < 40) begin
      chk("busy_run", busy, 1);
      chk("flags_hold", {L, E, G}, prev);
      @(posedge clk);
      #1;
      n++;
    end
    start = 1'b0;
    chk("latency", n, exp_k8(x, y));
    chk("result_leg", {L, E, G}, e);
    chk("busy_at_done", busy, 0);
    prev = e;
    @(posedge clk);
    #1;
    chk("done_fall", done, 0);
    chk("busy_idle", busy, 0);
    chk("flags_after", {L, E, G}, prev);
  endtask

  task automatic run2(input logic [1:0] x, input logic [1:0] y);
    @(negedge clk);
    start2 = 1'b1;
    a2 = x;
    b2 = y;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    a2 = 2'($urandom);
    b2 = 2'($urandom);
    chk("w2_busy_t0", busy2, 1);
    chk("w2_done_t0", done2, 0);
    @(posedge clk);
    #1;
    chk("w2_done_t1", done2, 1);
    chk("w2_busy_t1", busy2, 0);
    chk("w2_leg", {L2, E2, G2}, exp_leg(x, y));
    @(posedge clk);
    #1;
    chk("w2_done_fall", done2, 0);
  endtask

  initial begin
    logic [7:0] x, y;
    n_chk  = 0;
    n_fail = 0;
    prev   = 3'b000;
    rst_n  = 1'b0;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    start2 = 1'b0;
    a2     = '0;
    b2     = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy_done", {busy, done}, 2'b00);
    chk("rst_leg", {L, E, G}, 3'b000);
    chk("rst_w2", {busy2, done2, L2, E2, G2}, 5'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Equal operands: all slices visited in both builds
    start8(8'hA5, 8'hA5);
    wait8(8'hA5, 8'hA5, 0);

    // MSB slice decides G; zero low slices must not disturb it
    start8(8'hC0, 8'h80);
    wait8(8'hC0, 8'h80, 0);

    // Decided only in the LSB slice, then a G result while L is held
    start8(8'h12, 8'h13);
    wait8(8'h12, 8'h13, 0);
    start8(8'h40, 8'h00);
    wait8(8'h40, 8'h00, 0);

    // start during RUN/DONE ignored, new operands ignored
    start8(8'h01, 8'h00);
    @(posedge clk);
    #1;
    start = 1'b1;
    a = 8'h00;
    b = 8'hFF;
    wait8(8'h01, 8'h00, 1);
    start8(8'h00, 8'hFF);
    wait8(8'h00, 8'hFF, 0);

    // Asynchronous reset mid-run clears everything immediately
    start8(8'h3C, 8'h3C);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy_done", {busy, done}, 2'b00);
    chk("midrst_leg", {L, E, G}, 3'b000);
    prev = 3'b000;
    @(negedge clk);
    rst_n = 1'b1;
    start8(8'h00, 8'h01);
    wait8(8'h00, 8'h01, 0);

    // Randomized compares against the model
    for (int i = 0; i < 40; i++) begin
      x = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       y = x;
        1:       y = x ^ 8'(1 << $urandom_range(0, 7));
        default: y = 8'($urandom);
      endcase
      start8(x, y);
      wait8(x, y, 0);
    end

    // Single-slice instance
    run2(2'b01, 2'b10);
    run2(2'b11, 2'b11);
    run2(2'b10, 2'b01);
    for (int i = 0; i < 8; i++) begin
      run2(2'($urandom), 2'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/comparator_seq_ctrl.md
Name: comparator_seq_ctrl

Overview:
- Sequencing controller that compares two WIDTH-bit unsigned operands by stepping a 2-bit magnitude-compare slice from the MSB pair down to the LSB pair, one slice per clock.
- Sits in front of the 2-bit comparator datapath. Wide compares reuse one small slice instead of a WIDTH-bit combinational comparator.
- Uses a start/busy/done handshake.
- Produces registered one-hot L/E/G flags, with the same meaning as the 2-bit comparator outputs.

Parameters:
- WIDTH, 8, operand width in bits. Must be even and >= 2. Number of slices is S = WIDTH/2.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a compare. Sampled only in IDLE.
- a  input  WIDTH  operand A. Captured on the accepting edge.
- b  input  WIDTH  operand B. Captured on the accepting edge.
- busy  output  1  high while a compare is in progress (RUN state).
- done  output  1  one-cycle pulse: result valid and just updated.
- L  output  1  A < B (registered, held).
- E  output  1  A == B (registered, held).
- G  output  1  A > B (registered, held).

Behaviour:
- Reset (async, rst_n=0):
  - busy=0, done=0, L=0, E=0, G=0.
  - FSM goes to IDLE; slice index and operand registers clear.
  - This takes effect immediately, including mid-compare. No partial result survives.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If start=1 at an edge: latch a and b, set idx=S-1, clear the internal decided/result state, go to RUN. busy=1 from that edge.
  - If start=0: stay in IDLE.
- RUN:
  - Each cycle, compare slice {a_q[2*idx+1], a_q[2*idx]} against the same bits of b_q, as unsigned 2-bit values.
  - The first slice that differs fixes the result: G if the A slice is larger, L if smaller.
  - If every slice is equal, the result is E.
  - Exit condition is per the Optional Feature. On exit, go to DONE: L/E/G are written with the result (exactly one high) and done=1 from that edge.
- DONE:
  - One cycle, busy=0, done=1. Then go to IDLE (done falls).
- Results:
  - L/E/G hold their value until the next DONE update, or until reset.
  - They are NOT cleared when a new start is accepted.
- Latency: start sampled at edge t0. If the FSM exits after k RUN cycles, done=1 and the new flags are visible after edge t0+k. A new start can be sampled no earlier than edge t0+k+2.
- start while in RUN or DONE is ignored. Changes on a/b after capture are ignored.
- start held high continuously gives back-to-back compares separated by one IDLE cycle.
- The slice index counts down only and never wraps.
- One-hot invariant: after the first compare, exactly one of L/E/G is 1 at all times.

Optional Feature:
- Macro: COMPARATOR_SEQ_EARLY_EXIT_EN.
- Defined: RUN exits on the first differing slice, or after slice 0 if all slices are equal. k = (number of equal MSB slices) + 1, capped at S.
- Undefined: RUN always runs all S slices (k = S, fixed latency).
  - The result is still decided by the first differing slice, which is held sticky.
  - Later slices must not overwrite it.
- L/E/G values are identical in both builds. Only the done timing differs.

Test Plan:
- WIDTH=8, a=0xA5, b=0xA5, start pulse -> E=1, L=0, G=0, done after edge t0+4 in both builds; busy high for exactly 4 cycles.
- WIDTH=8, a=0xC0, b=0x80 -> G=1. done after t0+1 with COMPARATOR_SEQ_EARLY_EXIT_EN, after t0+4 without it. Lower slices (0x00 vs 0x00) must not change the result.
- WIDTH=8, a=0x12, b=0x13 -> L=1, done after t0+4 in both builds. Then a=0x40, b=0x00 -> G=1; L/E/G hold L=1 until that done.
- WIDTH=8, a=0x01, b=0x00 started; at t0+2 drive start=1 with a=0x00, b=0xFF -> second start ignored, result G=1. A fresh start after done returns to IDLE gives L=1.
- Reset mid-run: after compare of a=0x3C, b=0x3C started, drop rst_n between t0+1 and t0+2 -> busy, done, L, E, G all 0 immediately. After release, a start with a=0x00, b=0x01 -> L=1.
- WIDTH=2, a=2'b01, b=2'b10 -> L=1, done after t0+1. a=2'b11, b=2'b11 -> E=1.
